// File: rtl/lfsr_gen.sv
// lfsr_gen: configurable Fibonacci/Galois LFSR with run-time seed load,
// multi-step advance per enable and zero-state lockup recovery.
// Optional feature macro: LFSR_PERIOD_EN adds wrap detection and period
// measurement (wrap / period_out); without it both outputs are tied to zero.
module lfsr_gen #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'h002D),
  parameter int               GALOIS       = 0,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period_out
);

  localparam logic [WIDTH-1:0] ONES       = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};
  // A zero seed would lock the register, so it is replaced by all-ones.
  localparam logic [WIDTH-1:0] RESET_SEED = (SEED_DEFAULT == ZERO) ? ONES : SEED_DEFAULT;

  // One LFSR shift in the configured structure.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (GALOIS != 0) begin
      r = {1'b0, s[WIDTH-1:1]} ^ ({WIDTH{s[0]}} & TAPS);
    end else begin
      r = {^(s & TAPS), s[WIDTH-1:1]};
    end
    return r;
  endfunction

  logic [WIDTH-1:0] value_r;
  logic             valid_r;
  logic             lockup_r;
  logic [WIDTH-1:0] adv_s;
  logic [WIDTH-1:0] seed_eff_s;
  logic [WIDTH-1:0] value_nxt_s;
  logic             valid_nxt_s;
  logic             lockup_nxt_s;
  logic             advance_s;

  assign seed_eff_s = (seed_in == ZERO) ? ONES : seed_in;

  // State after STEPS shifts, unrolled so the whole advance fits in one cycle.
  always_comb begin
    adv_s = value_r;
    for (int i = 0; i < STEPS; i++) begin
      adv_s = lfsr_step(adv_s);
    end
  end

  // Next-state selection: load beats lockup recovery, which beats enable.
  always_comb begin
    value_nxt_s  = value_r;
    valid_nxt_s  = valid_r;
    lockup_nxt_s = 1'b0;
    advance_s    = 1'b0;
    if (seed_load) begin
      value_nxt_s  = seed_eff_s;
      valid_nxt_s  = 1'b0;
      lockup_nxt_s = (seed_in == ZERO);
    end else if (value_r == ZERO) begin
      value_nxt_s  = ONES;
      lockup_nxt_s = 1'b1;
    end else if (enable) begin
      value_nxt_s = adv_s;
      valid_nxt_s = 1'b1;
      advance_s   = 1'b1;
    end else begin
      value_nxt_s = value_r;
    end
  end

  // Core state, valid and lockup registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r  <= RESET_SEED;
      valid_r  <= 1'b0;
      lockup_r <= 1'b0;
    end else begin
      value_r  <= value_nxt_s;
      valid_r  <= valid_nxt_s;
      lockup_r <= lockup_nxt_s;
    end
  end

  assign value  = value_r;
  assign valid  = valid_r;
  assign lockup = lockup_r;

`ifdef LFSR_PERIOD_EN
  localparam logic [WIDTH:0] STEP_INC = (WIDTH+1)'(STEPS);

  logic [WIDTH-1:0] seed_r;
  logic [WIDTH:0]   cnt_r;
  logic             wrap_r;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH:0]   cnt_inc_s;

  assign cnt_inc_s = cnt_r + STEP_INC;

  // Track steps since the seed and report the period when the seed recurs.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_r   <= RESET_SEED;
      cnt_r    <= {(WIDTH+1){1'b0}};
      wrap_r   <= 1'b0;
      period_r <= ZERO;
    end else if (seed_load) begin
      seed_r <= seed_eff_s;
      cnt_r  <= {(WIDTH+1){1'b0}};
      wrap_r <= 1'b0;
    end else if (advance_s) begin
      if (adv_s == seed_r) begin
        wrap_r   <= 1'b1;
        period_r <= cnt_inc_s[WIDTH-1:0];
        cnt_r    <= {(WIDTH+1){1'b0}};
      end else begin
        wrap_r <= 1'b0;
        cnt_r  <= cnt_inc_s;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign wrap       = wrap_r;
  assign period_out = period_r;
`else
  assign wrap       = 1'b0;
  assign period_out = ZERO;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen (4-bit configurations).
module tb_lfsr_gen;

  typedef struct packed {
    logic [3:0] val;
    logic       valid;
    logic       lock;
    logic       wrap;
    logic [3:0] per;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic seed_load = 1'b0;
  logic [3:0] seed_in = 4'h0;

  logic [3:0] f1_value, f1_period, f2_value, f2_period, g_value, g_period, z_value, z_period;
  logic f1_valid, f1_lockup, f1_wrap;
  logic f2_valid, f2_lockup, f2_wrap;
  logic g_valid, g_lockup, g_wrap;
  logic z_valid, z_lockup, z_wrap;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  // Reference model state for the main Fibonacci STEPS=1 instance.
  logic [3:0] m_val;
  logic       m_valid, m_lock, m_wrap;
  logic [4:0] m_cnt;
  logic [3:0] m_seed, m_per;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .GALOIS(0), .STEPS(1), .SEED_DEFAULT(4'b1111)) u_f1 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
    .value(f1_value), .valid(f1_valid), .lockup(f1_lockup), .wrap(f1_wrap), .period_out(f1_period));

  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .GALOIS(0), .STEPS(2), .SEED_DEFAULT(4'b1111)) u_f2 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
    .value(f2_value), .valid(f2_valid), .lockup(f2_lockup), .wrap(f2_wrap), .period_out(f2_period));

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .GALOIS(1), .STEPS(1), .SEED_DEFAULT(4'b1111)) u_gal (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
    .value(g_value), .valid(g_valid), .lockup(g_lockup), .wrap(g_wrap), .period_out(g_period));

  // Zero tap mask: the register drains to zero, exercising lockup recovery.
  lfsr_gen #(.WIDTH(4), .TAPS(4'b0000), .GALOIS(0), .STEPS(1), .SEED_DEFAULT(4'b0000)) u_zero (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
    .value(z_value), .valid(z_valid), .lockup(z_lockup), .wrap(z_wrap), .period_out(z_period));

  function automatic logic [3:0] fib_step(input logic [3:0] s);
    logic fb;
    fb = ^(s & 4'b0011);
    return {fb, s[3:1]};
  endfunction

  // Drive one cycle, predict the main instance's outputs, queue them, clock.
  task automatic apply(input logic r, input logic en, input logic ld, input logic [3:0] sd);
    exp_t e;
    logic [3:0] n;
    reset = r; enable = en; seed_load = ld; seed_in = sd;
    if (r) begin
      m_val = 4'hF; m_valid = 1'b0; m_lock = 1'b0; m_wrap = 1'b0;
      m_cnt = 5'd0; m_seed = 4'hF; m_per = 4'h0;
    end else if (ld) begin
      m_val = (sd == 4'h0) ? 4'hF : sd;
      m_valid = 1'b0; m_lock = (sd == 4'h0); m_wrap = 1'b0;
      m_cnt = 5'd0; m_seed = m_val;
    end else if (m_val == 4'h0) begin
      m_val = 4'hF; m_lock = 1'b1; m_wrap = 1'b0;
    end else if (en) begin
      n = fib_step(m_val);
      m_valid = 1'b1; m_lock = 1'b0;
      if (n == m_seed) begin
        m_wrap = 1'b1; m_per = m_cnt[3:0] + 4'd1; m_cnt = 5'd0;
      end else begin
        m_wrap = 1'b0; m_cnt = m_cnt + 5'd1;
      end
      m_val = n;
    end else begin
      m_lock = 1'b0; m_wrap = 1'b0;
    end
    e.val = m_val; e.valid = m_valid; e.lock = m_lock;
`ifdef LFSR_PERIOD_EN
    e.wrap = m_wrap; e.per = m_per;
`else
    e.wrap = 1'b0; e.per = 4'h0;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply(1'b1, 1'b1, 1'b1, 4'h5);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL reset_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== 11'b1111_0_0_0_0000) begin
      bad++; $display("FAIL reset_const got=%b exp=11110000000", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period});
    end
  endtask

  task automatic test_fib_sequence();
    exp_t e;
    logic [3:0] fib_exp [4] = '{4'b0111, 4'b0011, 4'b0001, 4'b1000};
    logic [3:0] zero_exp [4] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0] f2_exp [2] = '{4'b0011, 4'b1000};
    apply(1'b0, 1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL fib_idle_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 1'b0, 4'h0);
      e = exp_q.pop_front(); total++;
      if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
        bad++; $display("FAIL fib_sb[%0d] got=%h exp=%h", i, {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
      end
      total++;
      if (f1_value !== fib_exp[i] || f1_valid !== 1'b1) begin
        bad++; $display("FAIL fib_const[%0d] got=%b/%b exp=%b/1", i, f1_value, f1_valid, fib_exp[i]);
      end
      total++;
      if (z_value !== zero_exp[i]) begin
        bad++; $display("FAIL zero_taps[%0d] got=%b exp=%b", i, z_value, zero_exp[i]);
      end
      if (i < 2) begin
        total++;
        if (f2_value !== f2_exp[i]) begin
          bad++; $display("FAIL steps2[%0d] got=%b exp=%b", i, f2_value, f2_exp[i]);
        end
      end
    end
    // State zero recovers to all-ones with a lockup pulse even without enable.
    apply(1'b0, 1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL hold_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    total++;
    if (z_value !== 4'b1111 || z_lockup !== 1'b1) begin
      bad++; $display("FAIL zero_recover got=%b/%b exp=1111/1", z_value, z_lockup);
    end
    apply(1'b0, 1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL hold2_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    total++;
    if (z_value !== 4'b1111 || z_lockup !== 1'b0) begin
      bad++; $display("FAIL zero_pulse_end got=%b/%b exp=1111/0", z_value, z_lockup);
    end
  endtask

  task automatic test_galois_load();
    exp_t e;
    logic [3:0] g_exp [3] = '{4'b1001, 4'b1101, 4'b1111};
    apply(1'b0, 1'b0, 1'b1, 4'b0001);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL gal_load_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    total++;
    if (g_value !== 4'b0001 || g_valid !== 1'b0) begin
      bad++; $display("FAIL gal_load got=%b/%b exp=0001/0", g_value, g_valid);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b0, 4'h0);
      e = exp_q.pop_front(); total++;
      if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
        bad++; $display("FAIL gal_sb[%0d] got=%h exp=%h", i, {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
      end
      total++;
      if (g_value !== g_exp[i] || g_valid !== 1'b1) begin
        bad++; $display("FAIL gal_step[%0d] got=%b/%b exp=%b/1", i, g_value, g_valid, g_exp[i]);
      end
    end
  endtask

  task automatic test_zero_seed();
    exp_t e;
    apply(1'b0, 1'b1, 1'b1, 4'h0);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL zseed_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    total++;
    if (f1_value !== 4'b1111 || f1_lockup !== 1'b1 || f1_valid !== 1'b0) begin
      bad++; $display("FAIL zseed_load got=%b/%b/%b exp=1111/1/0", f1_value, f1_lockup, f1_valid);
    end
    apply(1'b0, 1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL zseed_after_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    total++;
    if (f1_lockup !== 1'b0 || f1_value !== 4'b1111) begin
      bad++; $display("FAIL zseed_pulse got=%b/%b exp=1111/0", f1_value, f1_lockup);
    end
  endtask

  task automatic test_period();
    exp_t e;
    int wraps = 0;
    int wraps_exp;
    apply(1'b0, 1'b0, 1'b1, 4'hF);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL per_load_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, 1'b1, 1'b0, 4'h0);
      e = exp_q.pop_front(); total++;
      if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
        bad++; $display("FAIL per_sb[%0d] got=%h exp=%h", i, {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
      end
      if (f1_wrap === 1'b1) wraps++;
    end
`ifdef LFSR_PERIOD_EN
    wraps_exp = 2;
`else
    wraps_exp = 0;
`endif
    total++;
    if (wraps != wraps_exp || f1_period !== ((wraps_exp == 2) ? 4'd15 : 4'd0)) begin
      bad++; $display("FAIL period got=wraps %0d period %0d exp=wraps %0d", wraps, f1_period, wraps_exp);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic r, en, ld;
    for (int i = 0; i < 200; i++) begin
      r  = ($urandom_range(63) == 0);
      ld = ($urandom_range(7) == 0);
      en = ($urandom_range(3) != 0);
      apply(r, en, ld, 4'($urandom_range(15)));
      e = exp_q.pop_front(); total++;
      if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
        bad++; $display("FAIL rand_sb[%0d] got=%h exp=%h", i, {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
      end
    end
  endtask

  task automatic test_reset_override();
    exp_t e;
    apply(1'b0, 1'b0, 1'b1, 4'h0);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL rst_pre_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    apply(1'b1, 1'b1, 1'b1, 4'h0);
    e = exp_q.pop_front(); total++;
    if ({f1_value, f1_valid, f1_lockup, f1_wrap, f1_period} !== e) begin
      bad++; $display("FAIL rst_ovr_sb got=%h exp=%h", {f1_value, f1_valid, f1_lockup, f1_wrap, f1_period}, e);
    end
    total++;
    if (f1_value !== 4'hF || f1_valid !== 1'b0 || f1_lockup !== 1'b0 || f1_wrap !== 1'b0 || z_value !== 4'hF) begin
      bad++; $display("FAIL rst_ovr got=%b/%b/%b/%b exp=1111/0/0/0", f1_value, f1_valid, f1_lockup, f1_wrap);
    end
  endtask

  initial begin
    test_reset();
    test_fib_sequence();
    test_galois_load();
    test_zero_seed();
    test_period();
    test_back_to_back();
    test_reset_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
